// File: rtl/rv32_cpu_cp_pkg.sv
// Shared definitions for the CPU co-processor issue path: FSM encodings, CP slot indices
// and control bit positions.
package rv32_cpu_cp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned CP_SHIFT    = 0;
    localparam int unsigned CP_MULDIV   = 1;
    localparam int unsigned CP_BITMANIP = 2;
    localparam int unsigned CP_CUSTOM   = 3;

    localparam int unsigned CTRL_SHIFT_RIGHT = 0;
    localparam int unsigned CTRL_SHIFT_ARITH = 1;

endpackage

// File: rtl/rv32_cpu_cp_watchdog.sv
// WAIT-state cycle counter; tc flags the last permitted wait cycle.
module rv32_cpu_cp_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rv32_cpu_cp_issue_ctrl.sv
// Issues one ALU-extension op to a selected co-processor and returns its registered result.
// Optional WAIT timeout enabled by defining RV32_CP_TIMEOUT_EN.
module rv32_cpu_cp_issue_ctrl
    import rv32_cpu_cp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_CP      = 4,
    parameter int unsigned CP_SEL_W    = 2,
    parameter int unsigned CTRL_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cpu_trap,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [CP_SEL_W-1:0]    i_cp_sel,
    input  logic [CTRL_W-1:0]      i_ctrl,
    input  logic [XLEN-1:0]        i_rs1,
    input  logic [XLEN-1:0]        i_rs2,
    output logic [NUM_CP-1:0]      o_cp_start,
    output logic [CTRL_W-1:0]      o_cp_ctrl,
    output logic [XLEN-1:0]        o_cp_rs1,
    output logic [XLEN-1:0]        o_cp_rs2,
    input  logic [NUM_CP*XLEN-1:0] i_cp_res,
    input  logic [NUM_CP-1:0]      i_cp_valid,
    output logic [XLEN-1:0]        o_res,
    output logic                   o_done,
    output logic                   o_err
);

    logic [1:0]          state, state_n;
    logic [CP_SEL_W-1:0] sel_q;
    logic                err_q, err_n;
    logic [NUM_CP-1:0]   sel_hit;
    logic                legal, sel_valid, accept, capture, timeout;
    logic [XLEN-1:0]     sel_res, cap_val;

    assign o_req_ready = (state == ST_IDLE) && !i_cpu_trap;
    assign accept      = i_req_valid && o_req_ready;

    // Decode the latched select once; an out-of-range select matches no slot.
    always_comb begin
        sel_hit = '0;
        sel_res = '0;
        for (int unsigned k = 0; k < NUM_CP; k++) begin
            if (sel_q == CP_SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
                sel_res    = i_cp_res[k*XLEN +: XLEN];
            end
        end
    end

    assign legal     = |sel_hit;
    assign sel_valid = |(sel_hit & i_cp_valid);

`ifdef RV32_CP_TIMEOUT_EN
    rv32_cpu_cp_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk (i_clk),
        .rst (i_rst),
        .clr (state == ST_ISSUE),
        .en  (state == ST_WAIT),
        .tc  (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        err_n   = err_q;
        capture = 1'b0;
        cap_val = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_ISSUE;
                    err_n   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (!legal) begin
                    state_n = ST_DONE;
                    capture = 1'b1;
                    err_n   = 1'b1;
                end else if (sel_valid) begin
                    state_n = ST_DONE;
                    capture = 1'b1;
                    cap_val = sel_res;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Valid on the terminal-count cycle still returns a normal result.
                if (sel_valid) begin
                    state_n = ST_DONE;
                    capture = 1'b1;
                    cap_val = sel_res;
                end else if (timeout) begin
                    state_n = ST_DONE;
                    capture = 1'b1;
                    err_n   = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (i_cpu_trap && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            err_q     <= 1'b0;
            sel_q     <= '0;
            o_cp_ctrl <= '0;
            o_cp_rs1  <= '0;
            o_cp_rs2  <= '0;
            o_res     <= '0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            if (accept) begin
                sel_q     <= i_cp_sel;
                o_cp_ctrl <= i_ctrl;
                o_cp_rs1  <= i_rs1;
                o_cp_rs2  <= i_rs2;
            end
            if (capture) begin
                o_res <= cap_val;
            end
        end
    end

    assign o_cp_start = (state == ST_ISSUE && !i_cpu_trap) ? sel_hit : '0;
    assign o_done     = (state == ST_DONE) && !i_cpu_trap;
    assign o_err      = o_done && err_q;

endmodule

// File: tb/tb_rv32_cpu_cp_issue_ctrl.sv
// Directed bench for rv32_cpu_cp_issue_ctrl with small behavioural CP models.
module tb_rv32_cpu_cp_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap = 1'b0;
    logic        req_valid = 1'b0;
    logic        req3_valid = 1'b0;
    logic [1:0]  cp_sel = '0;
    logic [3:0]  ctrl = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        cp3_force = 1'b0;
    logic [31:0] cp3_res = '0;

    logic        ready, done, err;
    logic [3:0]  cp_start, cp_ctrl;
    logic [31:0] cp_rs1, cp_rs2, res;
    logic [127:0] cp_res;
    logic [3:0]  cp_valid;

    logic        ready3, done3, err3;
    logic [2:0]  start3;
    logic [3:0]  ctrl3;
    logic [31:0] rs1_3, rs2_3, res3;

    logic [31:0] res0, res1;
    int          md_cnt = 0;
    int          cmp = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    // Shifter: combinational, valid with start.
    always_comb begin
        if (cp_ctrl[0])
            res0 = cp_ctrl[1] ? 32'($signed(cp_rs1) >>> cp_rs2[4:0]) : (cp_rs1 >> cp_rs2[4:0]);
        else
            res0 = cp_rs1 << cp_rs2[4:0];
    end
    // Muldiv: valid exactly 5 cycles after its start pulse.
    assign res1 = cp_rs1 * cp_rs2;
    always @(posedge clk) begin
        if (cp_start[1]) md_cnt <= 1;
        else if (md_cnt >= 1 && md_cnt < 5) md_cnt <= md_cnt + 1;
        else md_cnt <= 0;
    end

    assign cp_res   = {cp3_res, 32'h0, res1, res0};
    assign cp_valid = {cp3_force, 1'b0, (md_cnt == 5), cp_start[0]};

    rv32_cpu_cp_issue_ctrl #(
        .XLEN(32), .NUM_CP(4), .CP_SEL_W(2), .CTRL_W(4), .TIMEOUT_CYC(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cpu_trap(trap), .i_req_valid(req_valid),
        .o_req_ready(ready), .i_cp_sel(cp_sel), .i_ctrl(ctrl), .i_rs1(rs1), .i_rs2(rs2),
        .o_cp_start(cp_start), .o_cp_ctrl(cp_ctrl), .o_cp_rs1(cp_rs1), .o_cp_rs2(cp_rs2),
        .i_cp_res(cp_res), .i_cp_valid(cp_valid), .o_res(res), .o_done(done), .o_err(err)
    );

    rv32_cpu_cp_issue_ctrl #(
        .XLEN(32), .NUM_CP(3), .CP_SEL_W(2), .CTRL_W(4), .TIMEOUT_CYC(8)
    ) dut3 (
        .i_clk(clk), .i_rst(rst), .i_cpu_trap(trap), .i_req_valid(req3_valid),
        .o_req_ready(ready3), .i_cp_sel(cp_sel), .i_ctrl(ctrl), .i_rs1(rs1), .i_rs2(rs2),
        .o_cp_start(start3), .o_cp_ctrl(ctrl3), .o_cp_rs1(rs1_3), .o_cp_rs2(rs2_3),
        .i_cp_res({64'h0, 32'hA5A5A5A5}), .i_cp_valid({2'b00, start3[0]}),
        .o_res(res3), .o_done(done3), .o_err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        cmp++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", ready); end
        cmp++; if (cp_start !== 4'b0000) begin errs++; $display("FAIL reset_start got=%b exp=0000", cp_start); end
        cmp++; if ({done, err} !== 2'b00) begin errs++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
        cmp++; if (res !== 32'h0) begin errs++; $display("FAIL reset_res got=%h exp=0", res); end
        cmp++; if ({cp_ctrl, cp_rs1, cp_rs2} !== '0) begin errs++; $display("FAIL reset_regs got=%h exp=0", {cp_ctrl, cp_rs1, cp_rs2}); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_shifter();
        cp_sel = 2'd0; ctrl = 4'b0011; rs1 = 32'h80000000; rs2 = 32'd4; req_valid = 1'b1;
        @(negedge clk);
        cmp++; if (ready !== 1'b1) begin errs++; $display("FAIL shift_ready got=%b exp=1", ready); end
        tick(); req_valid = 1'b0;
        @(negedge clk);
        cmp++; if (cp_start !== 4'b0001) begin errs++; $display("FAIL shift_start got=%b exp=0001", cp_start); end
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL shift_early_done got=%b exp=0", done); end
        tick();
        @(negedge clk);
        cmp++; if (cp_start !== 4'b0000) begin errs++; $display("FAIL shift_start_once got=%b exp=0000", cp_start); end
        cmp++; if ({done, err} !== 2'b10) begin errs++; $display("FAIL shift_done got=%b exp=10", {done, err}); end
        cmp++; if (res !== 32'hF8000000) begin errs++; $display("FAIL shift_res got=%h exp=f8000000", res); end
        tick();
        @(negedge clk);
        cmp++; if ({done, ready} !== 2'b01) begin errs++; $display("FAIL shift_idle got=%b exp=01", {done, ready}); end
        tick();
    endtask

    task automatic test_muldiv();
        cp_sel = 2'd1; ctrl = 4'b0000; rs1 = 32'd7; rs2 = 32'd6; req_valid = 1'b1;
        cp3_force = 1'b1; cp3_res = 32'hDEADBEEF;
        tick(); req_valid = 1'b0;
        @(negedge clk);
        cmp++; if (cp_start !== 4'b0010) begin errs++; $display("FAIL md_start got=%b exp=0010", cp_start); end
        for (int k = 2; k <= 7; k++) begin
            tick();
            @(negedge clk);
            if (k < 7) begin
                cmp++; if ({done, ready} !== 2'b00) begin errs++; $display("FAIL md_wait%0d got=%b exp=00", k, {done, ready}); end
            end else begin
                cmp++; if ({done, err} !== 2'b10) begin errs++; $display("FAIL md_done got=%b exp=10", {done, err}); end
                cmp++; if (res !== 32'd42) begin errs++; $display("FAIL md_res got=%0d exp=42", res); end
            end
        end
        cp3_force = 1'b0;
        tick();
    endtask

    task automatic test_trap_wait();
        cp_sel = 2'd1; rs1 = 32'd9; rs2 = 32'd9; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick();
        tick(); trap = 1'b1;
        @(negedge clk);
        cmp++; if ({done, ready} !== 2'b00) begin errs++; $display("FAIL trapw_cycle got=%b exp=00", {done, ready}); end
        tick(); trap = 1'b0;
        @(negedge clk);
        cmp++; if (ready !== 1'b1) begin errs++; $display("FAIL trapw_idle got=%b exp=1", ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            cmp++; if (done !== 1'b0 || res !== 32'd42) begin errs++; $display("FAIL trapw_late%0d got=%b/%0d exp=0/42", k, done, res); end
        end
        cp_sel = 2'd0; ctrl = 4'b0000; rs1 = 32'h12345678; rs2 = 32'd8; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick();
        @(negedge clk);
        cmp++; if (done !== 1'b1 || res !== 32'h34567800) begin errs++; $display("FAIL trapw_next got=%b/%h exp=1/34567800", done, res); end
        tick();
    endtask

    task automatic test_trap_valid();
        cp_sel = 2'd1; rs1 = 32'd3; rs2 = 32'd5; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        trap = 1'b1;
        @(negedge clk);
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL trapv_done got=%b exp=0", done); end
        tick(); trap = 1'b0;
        @(negedge clk);
        cmp++; if ({done, ready} !== 2'b01) begin errs++; $display("FAIL trapv_idle got=%b exp=01", {done, ready}); end
        cmp++; if (res !== 32'h34567800) begin errs++; $display("FAIL trapv_res got=%h exp=34567800", res); end
        tick();
        @(negedge clk);
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL trapv_after got=%b exp=0", done); end
    endtask

    task automatic test_slot_hold();
        cp_sel = 2'd3; cp3_force = 1'b1; cp3_res = 32'hCAFEF00D; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        @(negedge clk);
        cmp++; if (cp_start !== 4'b1000) begin errs++; $display("FAIL hold_start got=%b exp=1000", cp_start); end
        tick();
        @(negedge clk);
        cmp++; if (done !== 1'b1 || res !== 32'hCAFEF00D) begin errs++; $display("FAIL hold_done got=%b/%h exp=1/cafef00d", done, res); end
        tick(); cp3_res = 32'h11111111;
        tick();
        @(negedge clk);
        cmp++; if (done !== 1'b0 || res !== 32'hCAFEF00D) begin errs++; $display("FAIL hold_idle got=%b/%h exp=0/cafef00d", done, res); end
        cp3_force = 1'b0;
        tick();
    endtask

    task automatic test_idle_trap();
        trap = 1'b1; cp_sel = 2'd0; req_valid = 1'b1;
        @(negedge clk);
        cmp++; if (ready !== 1'b0) begin errs++; $display("FAIL itrap_ready got=%b exp=0", ready); end
        tick(); trap = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        cmp++; if ({cp_start, ready} !== 5'b00001) begin errs++; $display("FAIL itrap_noissue got=%b exp=00001", {cp_start, ready}); end
        tick();
    endtask

    task automatic test_illegal_sel();
        cp_sel = 2'd0; req3_valid = 1'b1;
        tick(); req3_valid = 1'b0;
        tick();
        @(negedge clk);
        cmp++; if (done3 !== 1'b1 || res3 !== 32'hA5A5A5A5) begin errs++; $display("FAIL ill_pre got=%b/%h exp=1/a5a5a5a5", done3, res3); end
        tick();
        cp_sel = 2'd3; req3_valid = 1'b1;
        @(negedge clk);
        cmp++; if (ready3 !== 1'b1) begin errs++; $display("FAIL ill_ready got=%b exp=1", ready3); end
        tick(); req3_valid = 1'b0;
        @(negedge clk);
        cmp++; if ({start3, done3} !== 4'b0000) begin errs++; $display("FAIL ill_start got=%b exp=0000", {start3, done3}); end
        tick();
        @(negedge clk);
        cmp++; if ({done3, err3} !== 2'b11) begin errs++; $display("FAIL ill_done got=%b exp=11", {done3, err3}); end
        cmp++; if (res3 !== 32'h0) begin errs++; $display("FAIL ill_res got=%h exp=0", res3); end
        tick();
        @(negedge clk);
        cmp++; if ({done3, err3, ready3} !== 3'b001) begin errs++; $display("FAIL ill_idle got=%b exp=001", {done3, err3, ready3}); end
    endtask

    task automatic test_no_valid();
        int hits;
        cp_sel = 2'd2; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
`ifdef RV32_CP_TIMEOUT_EN
        for (int k = 2; k <= 10; k++) begin
            tick();
            @(negedge clk);
            if (k < 10) begin
                cmp++; if (done !== 1'b0) begin errs++; $display("FAIL to_wait%0d got=%b exp=0", k, done); end
            end else begin
                cmp++; if ({done, err} !== 2'b11 || res !== 32'h0) begin errs++; $display("FAIL to_done got=%b/%h exp=11/0", {done, err}, res); end
            end
        end
        hits = 0;
        tick();
`else
        hits = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            @(negedge clk);
            if (done !== 1'b0 || ready !== 1'b0) hits++;
        end
        cmp++; if (hits !== 0) begin errs++; $display("FAIL nv_wait got=%0d exp=0", hits); end
        trap = 1'b1;
        tick(); trap = 1'b0;
        @(negedge clk);
        cmp++; if (ready !== 1'b1) begin errs++; $display("FAIL nv_trap_exit got=%b exp=1", ready); end
        tick();
`endif
    endtask

    task automatic test_async_reset();
        cp_sel = 2'd2; rs1 = 32'h55; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        cmp++; if ({ready, cp_start, done} !== 6'b100000) begin errs++; $display("FAIL arst_ctrl got=%b exp=100000", {ready, cp_start, done}); end
        cmp++; if (cp_rs1 !== 32'h0 || res !== 32'h0) begin errs++; $display("FAIL arst_regs got=%h/%h exp=0/0", cp_rs1, res); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_shifter();
        test_muldiv();
        test_trap_wait();
        test_trap_valid();
        test_slot_hold();
        test_idle_trap();
        test_illegal_sel();
        test_no_valid();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
